ram_array_write_unbias: RTL and testbench
=========================================

# ram_array_write_unbias

Write-side counterpart of the biased RAM-array reader. It accepts the skewed output wavefront of the systolic array, one ARRAY_SIZE-wide vector per valid beat, in which lane i lags lane 0 by i beats when the bias is enabled. It removes that skew and writes each lane into its own RAM bank at a de-biased address. Banks can be read back one word at a time by the host or a later layer.

## Interface
- DATA_WIDTH, 16, width of one lane word
- ADDR_WIDTH, 12, bank address width; each bank holds 2^ADDR_WIDTH words
- ARRAY_SIZE, 8, number of lanes and banks
- RAM_INDEX_ADDR_SIZE, 8, width of size and bank-index fields

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a transfer when the block is idle
- addr_bias  in  1  1: lane i is skewed by i beats; 0: no skew
- max_addr_size  in  RAM_INDEX_ADDR_SIZE  words per bank per transfer (N)
- max_ram_size  in  RAM_INDEX_ADDR_SIZE  active lanes (M); values above ARRAY_SIZE are clamped to ARRAY_SIZE
- write_start_addr  in  ADDR_WIDTH  base bank address
- in_valid  in  1  in_data holds one beat
- in_data  in  DATA_WIDTH*ARRAY_SIZE  lane i is bits [DW*(i+1)-1 : DW*i]
- busy  out  1  high in RUN and DONE
- done  out  1  one-cycle completion pulse
- beat_count  out  RAM_INDEX_ADDR_SIZE+1  beats accepted so far
- read_req  in  1  readback request
- read_ram_addr  in  RAM_INDEX_ADDR_SIZE  bank index to read
- read_addr  in  ADDR_WIDTH  word address to read
- read_data  out  DATA_WIDTH  readback word
- read_valid  out  1  read_data is valid

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE**
  - On start, latch addr_bias, N, M (clamped) and write_start_addr; clear beat_count.
  - If N==0 or M==0, go to DONE; otherwise go to RUN.
- **RUN**
  - Each cycle with in_valid=1, beat c = beat_count, and bias b_i = addr_bias ? i : 0.
  - Lane i writes bank i when all of these hold: i<M, c>=b_i, c<N+b_i.
  - Write address: write_start_addr + c - b_i, truncated to ADDR_WIDTH, so it wraps modulo 2^ADDR_WIDTH.
  - Lanes that fail the condition write nothing.
  - Beat count increments by 1 per valid beat.
  - Total beats L = N + (addr_bias ? M-1 : 0).
  - When the beat with c==L-1 is accepted, go to DONE.
  - in_valid gaps are allowed; there is no back-pressure.
- **DONE**
  - done=1 for exactly one cycle, then go to IDLE.
- start is ignored while not in IDLE.
- in_valid outside RUN is ignored.
- Readback
  - read_req samples read_ram_addr and read_addr.
  - read_ram_addr >= ARRAY_SIZE returns 0.
  - Reads are allowed in any state.
  - A read and a write to the same bank and address in the same cycle return the old data.
- Arithmetic
  - Beat counter is RAM_INDEX_ADDR_SIZE+1 bits; L is computed at that width.
  - Bias comparisons are unsigned.

## Timing
- Reset (reset=0) values: state IDLE, busy 0, done 0, beat_count 0, read_data 0, read_valid 0. Bank contents are not reset.
- A start sampled at edge T gives busy=1 from T+1.
- A beat sampled at edge T is written at edge T; a read issued at T+1 returns it.
- The last beat sampled at edge T gives done=1 during cycle T+1 and busy=0 from T+2.
- Degenerate start (N==0 or M==0) at edge T gives done=1 during cycle T+1 with no writes.
- Readback latency is 1 cycle: read_req at edge T gives read_valid=1 and read_data valid during cycle T+1.
- read_valid is 0 in cycles with no request; read_data holds its last value.
- Reset asserted mid-transfer:
  - Return to IDLE immediately; no done pulse.
  - Words already written are kept; remaining beats are not written.

## Test plan
- **Unskewed transfer.** addr_bias=0, N=4, M=8, base 0x010; feed 4 beats, lane i of beat k = (i<<8)|k. Required: bank i addr 0x010+k = (i<<8)|k; done pulses in the cycle after beat 4; beat_count reads 4.
- **Skewed transfer.** addr_bias=1, N=3, M=4, banks pre-filled with 0xFFFF; feed 6 beats. Required: bank i addr 0x010+k-i = lane i of beat k, for i<=k<i+3; banks 4-7 and all other addresses stay 0xFFFF.
- **Gapped input.** Repeat the unskewed transfer with in_valid toggling 1,0,1,0. Required: identical bank contents; done follows the 4th valid beat.
- **Address wrap.** base 0xFFE, N=4, addr_bias=0. Required: writes land at 0xFFE, 0xFFF, 0x000, 0x001.
- **Reset mid-run.** Assert reset after 2 of 4 beats. Required: busy=0, done never pulses, first 2 words retained, words 3-4 unchanged. A new start then completes normally.
- **Degenerate start and out-of-range read.** start with N=0. Required: done in the next cycle, no writes. A read of read_ram_addr=9 returns 0 with read_valid=1 one cycle later.

Source files
------------

// File: rtl/ram_array_write_unbias.sv
// Write-side de-skew for the systolic array output wavefront.
// Each lane writes its own RAM bank at base + beat - lane_bias.
// Banks can be read back one word at a time with one cycle of latency.
module ram_array_write_unbias #(
  parameter int unsigned DATA_WIDTH          = 16,
  parameter int unsigned ADDR_WIDTH          = 12,
  parameter int unsigned ARRAY_SIZE          = 8,
  parameter int unsigned RAM_INDEX_ADDR_SIZE = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           addr_bias,
  input  logic [RAM_INDEX_ADDR_SIZE-1:0] max_addr_size,
  input  logic [RAM_INDEX_ADDR_SIZE-1:0] max_ram_size,
  input  logic [ADDR_WIDTH-1:0]          write_start_addr,
  input  logic                           in_valid,
  input  logic [DATA_WIDTH*ARRAY_SIZE-1:0] in_data,
  output logic                           busy,
  output logic                           done,
  output logic [RAM_INDEX_ADDR_SIZE:0]   beat_count,
  input  logic                           read_req,
  input  logic [RAM_INDEX_ADDR_SIZE-1:0] read_ram_addr,
  input  logic [ADDR_WIDTH-1:0]          read_addr,
  output logic [DATA_WIDTH-1:0]          read_data,
  output logic                           read_valid
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;
  localparam int unsigned CntW  = RAM_INDEX_ADDR_SIZE + 1;
  localparam int unsigned BankW = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                         state_q, state_d;
  logic                           bias_q, bias_d;
  logic [RAM_INDEX_ADDR_SIZE-1:0] n_q, n_d;
  logic [RAM_INDEX_ADDR_SIZE-1:0] m_q, m_d;
  logic [ADDR_WIDTH-1:0]          base_q, base_d;
  logic [CntW-1:0]                beat_count_q, beat_count_d;
  logic [DATA_WIDTH-1:0]          read_data_q, read_data_d;
  logic                           read_valid_q, read_valid_d;

  logic [RAM_INDEX_ADDR_SIZE-1:0] m_clamped;
  logic [CntW-1:0]                total_len;
  logic                           beat_fire;
  logic                           last_beat;

  logic [CntW-1:0]                lane_bias [ARRAY_SIZE];
  logic [ARRAY_SIZE-1:0]          lane_we;
  logic [ADDR_WIDTH-1:0]          lane_addr [ARRAY_SIZE];

  // Bank storage; intentionally not reset.
  logic [DATA_WIDTH-1:0]          bank_mem [ARRAY_SIZE][Depth];

  // Transfer bookkeeping: clamp lane count, total beat length, last-beat detect.
  always_comb begin
    m_clamped = (max_ram_size > RAM_INDEX_ADDR_SIZE'(ARRAY_SIZE)) ?
                RAM_INDEX_ADDR_SIZE'(ARRAY_SIZE) : max_ram_size;
    total_len = CntW'(n_q) + (bias_q ? (CntW'(m_q) - CntW'(1)) : '0);
    beat_fire = (state_q == StRun) && in_valid;
    last_beat = beat_fire && (beat_count_q == total_len - CntW'(1));
  end

  // Per-lane write enable and de-biased address; lanes outside their window stay quiet.
  always_comb begin
    for (int i = 0; i < ARRAY_SIZE; i++) begin
      lane_bias[i] = bias_q ? CntW'(i) : '0;
      lane_we[i]   = beat_fire &&
                     (CntW'(i) < CntW'(m_q)) &&
                     (beat_count_q >= lane_bias[i]) &&
                     (beat_count_q < (CntW'(n_q) + lane_bias[i]));
      lane_addr[i] = base_q + ADDR_WIDTH'(beat_count_q - lane_bias[i]);
    end
  end

  // Bank writes; a same-cycle read sees the pre-write word.
  always_ff @(posedge clk) begin
    for (int i = 0; i < ARRAY_SIZE; i++) begin
      if (lane_we[i]) begin
        bank_mem[i][lane_addr[i]] <= in_data[DATA_WIDTH*i +: DATA_WIDTH];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = ((max_addr_size == '0) || (m_clamped == '0)) ? StDone : StRun;
        end
      end
      StRun:  if (last_beat) state_d = StDone;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy = (state_q == StRun) || (state_q == StDone);
    done = (state_q == StDone);
  end

  // Transfer parameters latched on start; beat counter advances per valid beat.
  always_comb begin
    bias_d       = bias_q;
    n_d          = n_q;
    m_d          = m_q;
    base_d       = base_q;
    beat_count_d = beat_count_q;
    if ((state_q == StIdle) && start) begin
      bias_d       = addr_bias;
      n_d          = max_addr_size;
      m_d          = m_clamped;
      base_d       = write_start_addr;
      beat_count_d = '0;
    end else if (beat_fire) begin
      beat_count_d = beat_count_q + CntW'(1);
    end
  end

  // Readback next-state: out-of-range bank reads as zero, data holds when idle.
  always_comb begin
    read_valid_d = read_req;
    read_data_d  = read_data_q;
    if (read_req) begin
      if (read_ram_addr < RAM_INDEX_ADDR_SIZE'(ARRAY_SIZE)) begin
        read_data_d = bank_mem[read_ram_addr[BankW-1:0]][read_addr];
      end else begin
        read_data_d = '0;
      end
    end
  end

  // Datapath and readback registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bias_q       <= 1'b0;
      n_q          <= '0;
      m_q          <= '0;
      base_q       <= '0;
      beat_count_q <= '0;
      read_data_q  <= '0;
      read_valid_q <= 1'b0;
    end else begin
      bias_q       <= bias_d;
      n_q          <= n_d;
      m_q          <= m_d;
      base_q       <= base_d;
      beat_count_q <= beat_count_d;
      read_data_q  <= read_data_d;
      read_valid_q <= read_valid_d;
    end
  end

  assign beat_count = beat_count_q;
  assign read_data  = read_data_q;
  assign read_valid = read_valid_q;

endmodule

// File: tb/tb_ram_array_write_unbias.sv
// Directed bench for ram_array_write_unbias: transfers, then readback against a scoreboard.
module tb_ram_array_write_unbias;

  localparam int DW = 16;
  localparam int AW = 12;
  localparam int AS = 8;
  localparam int RI = 8;

  logic            clk;
  logic            reset;
  logic            start;
  logic            addr_bias;
  logic [RI-1:0]   max_addr_size;
  logic [RI-1:0]   max_ram_size;
  logic [AW-1:0]   write_start_addr;
  logic            in_valid;
  logic [DW*AS-1:0] in_data;
  logic            busy;
  logic            done;
  logic [RI:0]     beat_count;
  logic            read_req;
  logic [RI-1:0]   read_ram_addr;
  logic [AW-1:0]   read_addr;
  logic [DW-1:0]   read_data;
  logic            read_valid;

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] sb [$];

  ram_array_write_unbias #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ARRAY_SIZE(AS), .RAM_INDEX_ADDR_SIZE(RI)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .addr_bias(addr_bias),
    .max_addr_size(max_addr_size), .max_ram_size(max_ram_size),
    .write_start_addr(write_start_addr), .in_valid(in_valid), .in_data(in_data),
    .busy(busy), .done(done), .beat_count(beat_count), .read_req(read_req),
    .read_ram_addr(read_ram_addr), .read_addr(read_addr), .read_data(read_data),
    .read_valid(read_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_xfer(input bit bias, input int n, input int m, input int base);
    @(negedge clk);
    start = 1'b1;
    addr_bias = bias;
    max_addr_size = RI'(n);
    max_ram_size = RI'(m);
    write_start_addr = AW'(base);
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", busy, 1);
  endtask

  // fill=1 drives the same word on every lane
  task automatic feed_beat(input int k, input logic [DW-1:0] dbase, input bit fill);
    @(negedge clk);
    in_valid = 1'b1;
    for (int i = 0; i < AS; i++) begin
      in_data[DW*i +: DW] = fill ? dbase : (dbase | DW'(i << 8) | DW'(k));
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic expect_done(input string tag);
    chk({tag, "_done"}, done, 1);
    @(posedge clk); #1;
    chk({tag, "_done_clr"}, done, 0);
    chk({tag, "_busy_clr"}, busy, 0);
  endtask

  task automatic rd_check(input int bank, input int addr, input logic [DW-1:0] exp);
    logic [DW-1:0] want;
    @(negedge clk);
    read_req = 1'b1;
    read_ram_addr = RI'(bank);
    read_addr = AW'(addr);
    sb.push_back(exp);
    @(posedge clk); #1;
    read_req = 1'b0;
    want = sb.pop_front();
    chk($sformatf("rd_valid_b%0d_a%0h", bank, addr), read_valid, 1);
    chk($sformatf("rd_b%0d_a%0h", bank, addr), read_data, want);
  endtask

  task automatic prefill(input int base, input int n, input logic [DW-1:0] val);
    start_xfer(1'b0, n, AS, base);
    for (int k = 0; k < n; k++) feed_beat(k, val, 1'b1);
    expect_done("prefill");
  endtask

  function automatic logic [DW-1:0] exp_skew(input int b, input int a);
    if (b < 4 && a >= 'h10 && a < 'h13) return DW'((b << 8) | 'h80 | (a - 'h10 + b));
    return 16'hFFFF;
  endfunction

  initial begin
    reset = 1'b0;
    start = 1'b0;
    addr_bias = 1'b0;
    max_addr_size = '0;
    max_ram_size = '0;
    write_start_addr = '0;
    in_valid = 1'b0;
    in_data = '0;
    read_req = 1'b0;
    read_ram_addr = '0;
    read_addr = '0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_beat_count", beat_count, 0);
    chk("rst_read_data", read_data, 0);
    chk("rst_read_valid", read_valid, 0);
    @(negedge clk);
    reset = 1'b1;

    // Unskewed transfer
    start_xfer(1'b0, 4, 8, 'h010);
    for (int k = 0; k < 4; k++) feed_beat(k, 16'h0000, 1'b0);
    chk("unskew_beat_count", beat_count, 4);
    expect_done("unskew");
    for (int i = 0; i < AS; i++)
      for (int k = 0; k < 4; k++) rd_check(i, 'h010 + k, DW'((i << 8) | k));

    // Gapped input, same shape with new data
    start_xfer(1'b0, 4, 8, 'h010);
    for (int k = 0; k < 4; k++) begin
      feed_beat(k, 16'h0040, 1'b0);
      if (k < 3) begin
        idle_cycle();
        chk("gap_no_done", done, 0);
      end
    end
    expect_done("gap");
    for (int i = 0; i < AS; i++)
      for (int k = 0; k < 4; k++) rd_check(i, 'h010 + k, DW'((i << 8) | 'h40 | k));

    // Skewed transfer over pre-filled banks
    prefill('h00C, 12, 16'hFFFF);
    start_xfer(1'b1, 3, 4, 'h010);
    for (int k = 0; k < 6; k++) begin
      if (k == 5) chk("skew_no_early_done", done, 0);
      feed_beat(k, 16'h0080, 1'b0);
    end
    chk("skew_beat_count", beat_count, 6);
    expect_done("skew");
    for (int b = 0; b < AS; b++)
      for (int a = 'h00E; a <= 'h014; a++) rd_check(b, a, exp_skew(b, a));

    // Address wrap, lane count above ARRAY_SIZE clamps
    start_xfer(1'b0, 4, 200, 'hFFE);
    for (int k = 0; k < 4; k++) feed_beat(k, 16'h0020, 1'b0);
    expect_done("wrap");
    for (int i = 0; i < AS; i++) begin
      rd_check(i, 'hFFE, DW'((i << 8) | 'h20 | 0));
      rd_check(i, 'hFFF, DW'((i << 8) | 'h20 | 1));
      rd_check(i, 'h000, DW'((i << 8) | 'h20 | 2));
      rd_check(i, 'h001, DW'((i << 8) | 'h20 | 3));
    end

    // Reset mid-run
    prefill('h100, 4, 16'hAAAA);
    start_xfer(1'b0, 4, 8, 'h100);
    feed_beat(0, 16'h0060, 1'b0);
    feed_beat(1, 16'h0060, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_beat_count", beat_count, 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst_done_after", done, 0);
    chk("midrst_busy_after", busy, 0);
    for (int i = 0; i < AS; i++) begin
      rd_check(i, 'h100, DW'((i << 8) | 'h60 | 0));
      rd_check(i, 'h101, DW'((i << 8) | 'h60 | 1));
      rd_check(i, 'h102, 16'hAAAA);
      rd_check(i, 'h103, 16'hAAAA);
    end
    // Fresh transfer after reset: bias on, 3 lanes, L = 4
    start_xfer(1'b1, 2, 3, 'h200);
    for (int k = 0; k < 4; k++) feed_beat(k, 16'h0070, 1'b0);
    expect_done("post_rst");
    rd_check(0, 'h201, 16'h0071);
    rd_check(2, 'h200, 16'h0272);
    rd_check(2, 'h201, 16'h0273);

    // Degenerate starts; stray in_valid outside RUN must not write
    start_xfer(1'b0, 0, 8, 'h010);
    chk("degen_n0_done", done, 1);
    in_valid = 1'b1;
    for (int i = 0; i < AS; i++) in_data[DW*i +: DW] = 16'h5555;
    @(posedge clk); #1;
    chk("degen_n0_done_clr", done, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    start_xfer(1'b0, 4, 0, 'h010);
    chk("degen_m0_done", done, 1);
    @(posedge clk); #1;
    chk("degen_m0_idle", busy, 0);
    rd_check(0, 'h010, 16'h0080);
    rd_check(5, 'h010, 16'hFFFF);
    rd_check(9, 'h010, 16'h0000);
    rd_check(0, 'h011, 16'h0081);
    idle_cycle();
    chk("rd_idle_valid", read_valid, 0);
    chk("rd_idle_hold", read_data, 16'h0081);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
